hs_source_arbiter: RTL and testbench

- Shares one 4-phase req/ack source channel between NUM_SRC local requesters.
- Uses round-robin arbitration, so no requester is starved.
- Sits between producer blocks and the sink-side handshake FSM, and owns req/data_out toward the sink.
- Latches the winner's data, runs the full handshake (req up, wait ack, req down, wait ack low), then pulses completion back to the winner.

---
 rtl/hs_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 27 ++
 rtl/hs_source_arbiter.sv | 126 ++++++++++++
 tb/tb_hs_source_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/hs_pkg.sv
// rtl/hs_pkg.sv - shared state encodings and defaults for the handshake source arbiter
package hs_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'b00,
        LOAD         = 2'b01,
        REQ_HI       = 2'b10,
        ACK_LOW_WAIT = 2'b11
    } hs_state_t;

    localparam int DATA_W_DEF = 8;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick: first valid requester at or after rr_ptr
module rr_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_SRC-1:0] valid,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic [ID_W-1:0]    winner,
    output logic               any_valid
);

    int idx;

    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        idx       = 0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_SRC;
            if (!any_valid && valid[idx]) begin
                any_valid = 1'b1;
                winner    = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/hs_source_arbiter.sv
// rtl/hs_source_arbiter.sv - round-robin sharing of one 4-phase req/ack source channel (option: HS_SOURCE_ARBITER_ACK_SYNC_EN)
module hs_source_arbiter
    import hs_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ID_W    = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_SRC-1:0]        src_valid,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    output logic [NUM_SRC-1:0]        src_done,
    output logic                      req,
    input  logic                      ack,
    output logic [DATA_W-1:0]         data_out,
    output logic                      busy,
    output logic [ID_W-1:0]           grant_id
);

    hs_state_t           state, state_n;
    logic                req_n;
    logic [DATA_W-1:0]   data_n;
    logic [NUM_SRC-1:0]  done_n;
    logic [ID_W-1:0]     grant_n;
    logic [ID_W-1:0]     rr_ptr, ptr_n;
    logic [ID_W-1:0]     win_id;
    logic                any_valid;
    logic                ack_i;

`ifdef HS_SOURCE_ARBITER_ACK_SYNC_EN
    logic ack_s1, ack_s2;

    always_ff @(posedge clk) begin
        if (reset) begin
            ack_s1 <= 1'b0;
            ack_s2 <= 1'b0;
        end else begin
            ack_s1 <= ack;
            ack_s2 <= ack_s1;
        end
    end

    assign ack_i = ack_s2;
`else
    assign ack_i = ack;
`endif

    rr_arbiter #(
        .NUM_SRC (NUM_SRC),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .valid     (src_valid),
        .rr_ptr    (rr_ptr),
        .winner    (win_id),
        .any_valid (any_valid)
    );

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            req      <= 1'b0;
            data_out <= '0;
            src_done <= '0;
            grant_id <= '0;
            rr_ptr   <= '0;
        end else begin
            state    <= state_n;
            req      <= req_n;
            data_out <= data_n;
            src_done <= done_n;
            grant_id <= grant_n;
            rr_ptr   <= ptr_n;
        end
    end

    always_comb begin
        state_n = state;
        req_n   = req;
        data_n  = data_out;
        done_n  = '0;
        grant_n = grant_id;
        ptr_n   = rr_ptr;
        case (state)
            IDLE: begin
                req_n  = 1'b0;
                data_n = '0;
                // A high ack_i here means the sink has not finished releasing yet.
                if (any_valid && !ack_i) begin
                    grant_n = win_id;
                    data_n  = src_data[int'(win_id)*DATA_W +: DATA_W];
                    state_n = LOAD;
                end
            end
            LOAD: begin
                // ack_i is deliberately ignored here; data_out gets a setup cycle before req.
                req_n   = 1'b1;
                state_n = REQ_HI;
            end
            REQ_HI: begin
                if (ack_i) begin
                    req_n            = 1'b0;
                    done_n[grant_id] = 1'b1;
                    ptr_n            = ID_W'((int'(grant_id) + 1) % NUM_SRC);
                    state_n          = ACK_LOW_WAIT;
                end
            end
            ACK_LOW_WAIT: begin
                if (!ack_i) begin
                    data_n  = '0;
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                req_n   = 1'b0;
                data_n  = '0;
                grant_n = '0;
                ptr_n   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_hs_source_arbiter.sv
// tb/tb_hs_source_arbiter.sv - randomized self-checking bench with transaction-level round-robin model
module tb_hs_source_arbiter;

`ifdef HS_SOURCE_ARBITER_ACK_SYNC_EN
    localparam int ACK_LAT = 2;
`else
    localparam int ACK_LAT = 0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  src_valid;
    logic [31:0] src_data;
    logic [3:0]  src_done;
    logic        req;
    logic        ack;
    logic [7:0]  data_out;
    logic        busy;
    logic [1:0]  grant_id;

    logic [3:0]  vld;
    logic [7:0]  dat [4];
    int          ptr;
    int          checks;
    int          errors;
    int          w;

    always #5 clk = ~clk;

    assign src_valid = vld;
    always_comb begin
        src_data = '0;
        for (int i = 0; i < 4; i++) src_data[i*8 +: 8] = dat[i];
    end

    hs_source_arbiter #(
        .NUM_SRC (4),
        .DATA_W  (8),
        .ID_W    (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .src_valid (src_valid),
        .src_data  (src_data),
        .src_done  (src_done),
        .req       (req),
        .ack       (ack),
        .data_out  (data_out),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic int pick(input logic [3:0] v, input int p);
        for (int k = 0; k < 4; k++) begin
            if (v[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_req", req, 0);
        chk("rst_data", data_out, 0);
        chk("rst_done", src_done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant_id, 0);
        reset = 1'b0;
        ptr   = 0;
    endtask

    // Entered at a negedge with the DUT idle, ack low and vld non-zero.
    task automatic run_xfer(input int ack_dly, input int rel_dly, input bit drop_mid,
                            input bit rearm, output int wo);
        logic [7:0] exp_d;
        wo    = pick(vld, ptr);
        exp_d = dat[wo];
        @(negedge clk);
        chk("grant_id", grant_id, wo);
        chk("setup_data", data_out, exp_d);
        chk("setup_req", req, 0);
        chk("busy_load", busy, 1);
        if (!rearm) dat[wo] = 8'($urandom);
        @(negedge clk);
        chk("req_rise", req, 1);
        chk("hold_data", data_out, exp_d);
        if (drop_mid) vld[wo] = 1'b0;
        for (int i = 0; i < ack_dly; i++) begin
            @(negedge clk);
            chk("req_hold", req, 1);
            chk("done_early", src_done, 0);
        end
        ack = 1'b1;
        repeat (ACK_LAT) begin
            @(negedge clk);
            chk("req_sync", req, 1);
            chk("done_sync", src_done, 0);
        end
        @(negedge clk);
        chk("done_pulse", src_done, 32'(1) << wo);
        chk("req_fall", req, 0);
        chk("busy_ack", busy, 1);
        ptr = (wo + 1) % 4;
        if (!rearm) vld[wo] = 1'b0;
        @(negedge clk);
        chk("done_once", src_done, 0);
        chk("data_alw", data_out, exp_d);
        for (int i = 0; i < rel_dly; i++) begin
            @(negedge clk);
            chk("req_low", req, 0);
            chk("busy_alw", busy, 1);
        end
        ack = 1'b0;
        repeat (ACK_LAT) begin
            @(negedge clk);
            chk("busy_rel", busy, 1);
        end
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_data", data_out, 0);
        chk("last_grant", grant_id, wo);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        ack    = 1'b0;
        vld    = '0;
        for (int i = 0; i < 4; i++) dat[i] = '0;
        ptr = 0;

        // single requester, sink acks 3 cycles after req
        do_reset();
        dat[2] = 8'hA5;
        vld    = 4'b0100;
        run_xfer(3, 1, 0, 0, w);
        chk("single_w", w, 2);
        // rr_ptr must now be 3: requester 3 beats requester 0
        dat[0] = 8'h11;
        dat[3] = 8'h33;
        vld    = 4'b1001;
        run_xfer(0, 0, 0, 0, w);
        chk("ptr_after_2", w, 3);
        vld = '0;

        // fairness with all four continuously valid
        do_reset();
        dat[0] = 8'h10; dat[1] = 8'h20; dat[2] = 8'h30; dat[3] = 8'h40;
        vld    = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            run_xfer(1, 0, 0, 1, w);
            chk("fair_order", w, n % 4);
            chk("fair_data", dat[w], 8'h10 * (w + 1));
        end
        vld = '0;

`ifndef HS_SOURCE_ARBITER_ACK_SYNC_EN
        // ack still high when reset releases
        ack = 1'b1;
        vld = 4'b0001;
        dat[0] = 8'h5C;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("ackhi_req", req, 0);
            chk("ackhi_busy", busy, 0);
        end
        ack = 1'b0;
        run_xfer(2, 0, 0, 0, w);
        chk("ackhi_w", w, 0);
`endif

        // reset while in REQ_HI
        do_reset();
        vld    = 4'b0010;
        dat[1] = 8'h77;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_req", req, 1);
        reset = 1'b1;
        vld   = '0;
        @(negedge clk);
        chk("midrst_req", req, 0);
        chk("midrst_data", data_out, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", src_done, 0);
        reset = 1'b0;
        ptr   = 0;
        @(negedge clk);
        chk("postrst_done", src_done, 0);
        chk("postrst_busy", busy, 0);

        // requester drops valid during REQ_HI
        dat[0] = 8'hC3; dat[1] = 8'h3C;
        vld    = 4'b0011;
        run_xfer(2, 1, 1, 0, w);
        chk("drop_w", w, 0);
        run_xfer(1, 0, 0, 0, w);
        chk("drop_skip", w, 1);

        // randomized traffic
        repeat (80) begin
            for (int i = 0; i < 4; i++) begin
                if (!vld[i] && $urandom_range(0, 1) == 1) begin
                    vld[i] = 1'b1;
                    dat[i] = 8'($urandom);
                end
            end
            if (vld == '0) begin
                @(negedge clk);
                chk("rand_idle_busy", busy, 0);
                chk("rand_idle_req", req, 0);
            end else begin
                run_xfer($urandom_range(0, 3), $urandom_range(0, 2),
                         $urandom_range(0, 3) == 0, 0, w);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
